// File: rtl/branch_predict_resolve.sv
// Conditional branch resolution from ALU flags, paired with a bimodal table of saturating
// counters that predicts for fetch and trains when the branch resolves.
module branch_predict_resolve #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2,
   parameter int STAT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [XLEN-1:0]       PC_F,
   output logic                  PredictTaken_F,
   input  logic                  Valid_C,
   input  logic [2:0]            ConditionalPCSrc_C,
   input  logic [XLEN-1:0]       PC_C,
   input  logic [XLEN-1:0]       BranchTarget_C,
   input  logic                  PredictedTaken_C,
   input  logic                  Zero_C,
   input  logic                  Carry_C,
   input  logic                  Negative_C,
   input  logic                  oVerflow_C,
   output logic                  Taken_C,
   output logic                  Mispredict_C,
   output logic [XLEN-1:0]       RedirectPC_C,
   output logic [STAT_WIDTH-1:0] BranchCount,
   output logic [STAT_WIDTH-1:0] MispredictCount
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [2:0] NO_BRANCH = 3'd0;
   localparam logic [2:0] BEQ_C     = 3'd1;
   localparam logic [2:0] BNE_C     = 3'd2;
   localparam logic [2:0] BLT_C     = 3'd3;
   localparam logic [2:0] BGE_C     = 3'd4;
   localparam logic [2:0] BLTU_C    = 3'd5;
   localparam logic [2:0] BGEU_C    = 3'd6;

   // Weakly not-taken; collapses to 0 for a 1-bit counter.
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   function automatic logic [CTR_BITS-1:0] ctr_sat_inc(input logic [CTR_BITS-1:0] c);
      return (&c) ? c : c + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] ctr_sat_dec(input logic [CTR_BITS-1:0] c);
      return (c == '0) ? c : c - CTR_BITS'(1);
   endfunction

   function automatic logic [STAT_WIDTH-1:0] stat_sat_inc(input logic [STAT_WIDTH-1:0] s);
      return (&s) ? s : s + STAT_WIDTH'(1);
   endfunction

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
   logic [IDX_W-1:0]    idx_f;
   logic [IDX_W-1:0]    idx_c;
   logic                cond_valid;
   logic                flag_taken;
   logic                resolving;
   logic                unused_pc_bits;

   assign idx_f          = PC_F[IDX_W+1:2];
   assign idx_c          = PC_C[IDX_W+1:2];
   assign unused_pc_bits = ^{PC_F[XLEN-1:IDX_W+2], PC_F[1:0]};

   assign PredictTaken_F = bht[idx_f][CTR_BITS-1];

   always_comb begin
      cond_valid = 1'b1;
      flag_taken = 1'b0;
      case (ConditionalPCSrc_C)
         BEQ_C:   flag_taken = Zero_C;
         BNE_C:   flag_taken = ~Zero_C;
         BLT_C:   flag_taken = Negative_C ^ oVerflow_C;
         BGE_C:   flag_taken = ~(Negative_C ^ oVerflow_C);
         BLTU_C:  flag_taken = Carry_C;
         BGEU_C:  flag_taken = ~Carry_C;
         NO_BRANCH: cond_valid = 1'b0;
         default: cond_valid = 1'b0;
      endcase
   end

   assign resolving    = Valid_C & cond_valid;
   assign Taken_C      = resolving & flag_taken;
   assign Mispredict_C = resolving & (Taken_C != PredictedTaken_C);
   assign RedirectPC_C = Mispredict_C ? (Taken_C ? BranchTarget_C : PC_C + XLEN'(4)) : '0;

   // Training and statistics: reset wins over a resolve in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_WNT;
         BranchCount     <= '0;
         MispredictCount <= '0;
      end else if (resolving) begin
         bht[idx_c]  <= Taken_C ? ctr_sat_inc(bht[idx_c]) : ctr_sat_dec(bht[idx_c]);
         BranchCount <= stat_sat_inc(BranchCount);
         if (Mispredict_C) MispredictCount <= stat_sat_inc(MispredictCount);
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: resolution table, BHT training and
// saturation, aliasing, mid-run reset and statistics saturation on a narrow instance.
module tb_branch_predict_resolve;

   localparam logic [2:0] NO_BRANCH = 3'd0;
   localparam logic [2:0] BEQ_C     = 3'd1;
   localparam logic [2:0] BNE_C     = 3'd2;
   localparam logic [2:0] BLT_C     = 3'd3;
   localparam logic [2:0] BGE_C     = 3'd4;
   localparam logic [2:0] BLTU_C    = 3'd5;
   localparam logic [2:0] BGEU_C    = 3'd6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] PC_F = '0;
   logic        Valid_C = 1'b0;
   logic [2:0]  ConditionalPCSrc_C = NO_BRANCH;
   logic [31:0] PC_C = '0;
   logic [31:0] BranchTarget_C = '0;
   logic        PredictedTaken_C = 1'b0;
   logic        Zero_C = 1'b0, Carry_C = 1'b0, Negative_C = 1'b0, oVerflow_C = 1'b0;

   logic        PredictTaken_F, Taken_C, Mispredict_C;
   logic [31:0] RedirectPC_C, BranchCount, MispredictCount;
   logic        PredictTaken_F4, Taken_C4, Mispredict_C4;
   logic [31:0] RedirectPC_C4;
   logic [3:0]  BranchCount4, MispredictCount4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predict_resolve dut (
      .clk(clk), .reset(reset), .PC_F(PC_F), .PredictTaken_F(PredictTaken_F),
      .Valid_C(Valid_C), .ConditionalPCSrc_C(ConditionalPCSrc_C), .PC_C(PC_C),
      .BranchTarget_C(BranchTarget_C), .PredictedTaken_C(PredictedTaken_C),
      .Zero_C(Zero_C), .Carry_C(Carry_C), .Negative_C(Negative_C), .oVerflow_C(oVerflow_C),
      .Taken_C(Taken_C), .Mispredict_C(Mispredict_C), .RedirectPC_C(RedirectPC_C),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   branch_predict_resolve #(.STAT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .PC_F(PC_F), .PredictTaken_F(PredictTaken_F4),
      .Valid_C(Valid_C), .ConditionalPCSrc_C(ConditionalPCSrc_C), .PC_C(PC_C),
      .BranchTarget_C(BranchTarget_C), .PredictedTaken_C(PredictedTaken_C),
      .Zero_C(Zero_C), .Carry_C(Carry_C), .Negative_C(Negative_C), .oVerflow_C(oVerflow_C),
      .Taken_C(Taken_C4), .Mispredict_C(Mispredict_C4), .RedirectPC_C(RedirectPC_C4),
      .BranchCount(BranchCount4), .MispredictCount(MispredictCount4)
   );

   task automatic set_br(input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic z, input logic c, input logic n,
                         input logic v);
      Valid_C = 1'b1;  ConditionalPCSrc_C = cond;  PC_C = pc;  BranchTarget_C = tgt;
      PredictedTaken_C = pred;  Zero_C = z;  Carry_C = c;  Negative_C = n;  oVerflow_C = v;
   endtask

   task automatic set_idle();
      Valid_C = 1'b0;  ConditionalPCSrc_C = NO_BRANCH;  PredictedTaken_C = 1'b0;
      Zero_C = 1'b0;  Carry_C = 1'b0;  Negative_C = 1'b0;  oVerflow_C = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         PC_F = 32'(i * 4);
         #1;
         checks++;
         if (PredictTaken_F !== 1'b0) begin
            errors++;
            $display("FAIL reset_predict idx=%0d got=%b exp=0", i, PredictTaken_F);
         end
      end
      checks++;
      if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts got=%0d/%0d exp=0/0", BranchCount, MispredictCount);
      end
      checks++;
      if (BranchCount4 !== 4'd0 || MispredictCount4 !== 4'd0) begin
         errors++;
         $display("FAIL reset_counts4 got=%0d/%0d exp=0/0", BranchCount4, MispredictCount4);
      end
      checks++;
      if (Taken_C !== 1'b0 || Mispredict_C !== 1'b0 || RedirectPC_C !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b %h exp=00 0", Taken_C, Mispredict_C, RedirectPC_C);
      end
   endtask

   task automatic test_beq();
      do_reset();
      @(negedge clk);
      set_br(BEQ_C, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      PC_F = 32'h100;
      #1;
      checks++;
      if (Taken_C !== 1'b1 || Mispredict_C !== 1'b1 || RedirectPC_C !== 32'h80) begin
         errors++;
         $display("FAIL beq_resolve got=%b%b %h exp=11 00000080", Taken_C, Mispredict_C, RedirectPC_C);
      end
      checks++;
      if (PredictTaken_F !== 1'b0) begin
         errors++;
         $display("FAIL beq_same_cycle_predict got=%b exp=0", PredictTaken_F);
      end
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b1) begin
         errors++;
         $display("FAIL beq_trained_predict got=%b exp=1", PredictTaken_F);
      end
      checks++;
      if (BranchCount !== 32'd1 || MispredictCount !== 32'd1) begin
         errors++;
         $display("FAIL beq_counts got=%0d/%0d exp=1/1", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_bne();
      do_reset();
      PC_F = 32'h200;
      @(negedge clk);
      set_br(BNE_C, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (Taken_C !== 1'b0 || Mispredict_C !== 1'b1 || RedirectPC_C !== 32'h204) begin
         errors++;
         $display("FAIL bne_resolve got=%b%b %h exp=01 00000204", Taken_C, Mispredict_C, RedirectPC_C);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_br(BNE_C, 32'h200, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         #1;
         checks++;
         if (Mispredict_C !== 1'b0 || RedirectPC_C !== 32'd0) begin
            errors++;
            $display("FAIL bne_correct k=%0d got=%b %h exp=0 0", k, Mispredict_C, RedirectPC_C);
         end
      end
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0) begin
         errors++;
         $display("FAIL bne_floor_predict got=%b exp=0", PredictTaken_F);
      end
      checks++;
      if (BranchCount !== 32'd5 || MispredictCount !== 32'd1) begin
         errors++;
         $display("FAIL bne_counts got=%0d/%0d exp=5/1", BranchCount, MispredictCount);
      end
      // Counter sits at 00: one taken reaches 01, prediction still not-taken.
      @(negedge clk);
      set_br(BNE_C, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0) begin
         errors++;
         $display("FAIL bne_floor_recover got=%b exp=0", PredictTaken_F);
      end
   endtask

   task automatic test_flags();
      logic [2:0] cv [10];
      logic       zv [10], cy [10], nv [10], vv [10], ev [10];
      cv = '{BLT_C, BGE_C, BLT_C, BGE_C, BLTU_C, BGEU_C, BLTU_C, BGEU_C, BEQ_C, BNE_C};
      zv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      cy = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      nv = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      vv = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      ev = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_br(cv[i], 32'h1000 + 32'(i * 4), 32'h2000, 1'b0, zv[i], cy[i], nv[i], vv[i]);
         #1;
         checks++;
         if (Taken_C !== ev[i] || Mispredict_C !== ev[i] ||
             RedirectPC_C !== (ev[i] ? 32'h2000 : 32'h0)) begin
            errors++;
            $display("FAIL flags_vec%0d got=%b%b %h exp=%b%b", i, Taken_C, Mispredict_C,
                     RedirectPC_C, ev[i], ev[i]);
         end
      end
      @(negedge clk);
      set_br(BEQ_C, 32'h300, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      Valid_C = 1'b0;
      #1;
      checks++;
      if (Taken_C !== 1'b0 || Mispredict_C !== 1'b0 || RedirectPC_C !== 32'd0) begin
         errors++;
         $display("FAIL flags_invalid got=%b%b %h exp=00 0", Taken_C, Mispredict_C, RedirectPC_C);
      end
      @(negedge clk);
      set_br(NO_BRANCH, 32'h300, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (Taken_C !== 1'b0 || Mispredict_C !== 1'b0 || RedirectPC_C !== 32'd0) begin
         errors++;
         $display("FAIL flags_nobranch got=%b%b %h exp=00 0", Taken_C, Mispredict_C, RedirectPC_C);
      end
      @(negedge clk);
      set_br(3'd7, 32'h300, 32'h2000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (Taken_C !== 1'b0 || Mispredict_C !== 1'b0 || RedirectPC_C !== 32'd0) begin
         errors++;
         $display("FAIL flags_undef got=%b%b %h exp=00 0", Taken_C, Mispredict_C, RedirectPC_C);
      end
      @(negedge clk);
      set_idle();
      PC_F = 32'h300;
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0 || BranchCount !== 32'd10 || MispredictCount !== 32'd5) begin
         errors++;
         $display("FAIL flags_no_update got=%b %0d/%0d exp=0 10/5", PredictTaken_F, BranchCount,
                  MispredictCount);
      end
   endtask

   task automatic test_alias();
      do_reset();
      @(negedge clk);
      set_br(BEQ_C, 32'h004, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      PC_F = 32'h104;
      #1;
      checks++;
      if (PredictTaken_F !== 1'b1) begin
         errors++;
         $display("FAIL alias_predict got=%b exp=1", PredictTaken_F);
      end
      PC_F = 32'h008;
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0) begin
         errors++;
         $display("FAIL alias_neighbour got=%b exp=0", PredictTaken_F);
      end
   endtask

   task automatic test_ctr_saturate();
      do_reset();
      PC_F = 32'h40;
      repeat (3) begin
         @(negedge clk);
         set_br(BEQ_C, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      set_br(BEQ_C, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b1) begin
         errors++;
         $display("FAIL ctr_saturate got=%b exp=1", PredictTaken_F);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      PC_F = 32'h600;
      @(negedge clk);
      set_br(BEQ_C, 32'h600, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pretrain got=%b exp=1", PredictTaken_F);
      end
      @(negedge clk);
      set_br(BEQ_C, 32'h500, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      set_idle();
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0) begin
         errors++;
         $display("FAIL midreset_entry600 got=%b exp=0", PredictTaken_F);
      end
      PC_F = 32'h500;
      #1;
      checks++;
      if (PredictTaken_F !== 1'b0 || BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         errors++;
         $display("FAIL midreset_discard got=%b %0d/%0d exp=0 0/0", PredictTaken_F, BranchCount,
                  MispredictCount);
      end
   endtask

   task automatic test_back_to_back_stats();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         set_br(BEQ_C, 32'h700, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (BranchCount !== 32'd20 || MispredictCount !== 32'd20) begin
         errors++;
         $display("FAIL stats_wide got=%0d/%0d exp=20/20", BranchCount, MispredictCount);
      end
      checks++;
      if (BranchCount4 !== 4'd15 || MispredictCount4 !== 4'd15) begin
         errors++;
         $display("FAIL stats_sat4 got=%0d/%0d exp=15/15", BranchCount4, MispredictCount4);
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_bne();
      test_flags();
      test_alias();
      test_ctr_saturate();
      test_reset_mid();
      test_back_to_back_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
